// File: rtl/sc_pointtype_ctrl.sv
// sc_pointtype_ctrl: turns start/left/right buttons into clear/load/rotate strobes for the point register,
// vetoing moves that would wrap or collide with the background row, with hold-to-repeat on direction buttons.
module sc_pointtype_ctrl #(
    parameter int DATAWIDTH     = 8,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int CNT_WIDTH     = 25
) (
    input  logic                 SC_RegPOINTTYPE_CLOCK_50,
    input  logic                 SC_RegPOINTTYPE_RESET_InHigh,
    input  logic                 SC_PointCtrl_start_InLow,
    input  logic                 SC_PointCtrl_left_InLow,
    input  logic                 SC_PointCtrl_right_InLow,
    input  logic [DATAWIDTH-1:0] SC_PointCtrl_piece_InBUS,
    input  logic [DATAWIDTH-1:0] SC_PointCtrl_background_InBUS,
    input  logic [DATAWIDTH-1:0] SC_PointCtrl_point_InBUS,
    output logic                 SC_PointCtrl_clear_OutLow,
    output logic                 SC_PointCtrl_load0_OutLow,
    output logic [1:0]           SC_PointCtrl_shiftselection_Out,
    output logic [DATAWIDTH-1:0] SC_PointCtrl_data0_OutBUS,
    output logic                 SC_PointCtrl_blocked_Out,
    output logic                 SC_PointCtrl_busy_Out
);
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, READY, SETTLE} state_t;
    state_t state, stateNext;
    logic [2:0] syncStart, syncLeft, syncRight;
    logic pressStart, pressLeft, pressRight;
    logic [CNT_WIDTH-1:0] count, limit;
    logic repeating, pend;
    logic heldLeft, heldRight, dirLeft, dirRight, inRun, clrCnt, hit, rep;
    logic moveLeft, moveRight, okLeft, okRight;
    logic [1:0] shiftNext;
    logic blockedNext;
    logic [DATAWIDTH-1:0] pt, bg;
    // bit 0/1 form the synchronizer, bit 2 holds the previous synchronized level for edge detection
    always_ff @(posedge SC_RegPOINTTYPE_CLOCK_50 or posedge SC_RegPOINTTYPE_RESET_InHigh) begin
        if (SC_RegPOINTTYPE_RESET_InHigh) begin
            syncStart  <= '1;
            syncLeft   <= '1;
            syncRight  <= '1;
            pressStart <= 1'b0;
            pressLeft  <= 1'b0;
            pressRight <= 1'b0;
        end else begin
            syncStart  <= {syncStart[1:0], SC_PointCtrl_start_InLow};
            syncLeft   <= {syncLeft[1:0], SC_PointCtrl_left_InLow};
            syncRight  <= {syncRight[1:0], SC_PointCtrl_right_InLow};
            pressStart <= syncStart[2] & ~syncStart[1];
            pressLeft  <= syncLeft[2] & ~syncLeft[1];
            pressRight <= syncRight[2] & ~syncRight[1];
        end
    end
    assign pt        = SC_PointCtrl_point_InBUS;
    assign bg        = SC_PointCtrl_background_InBUS;
    assign heldLeft  = ~syncLeft[1];
    assign heldRight = ~syncRight[1];
    assign dirLeft   = heldLeft & ~heldRight;
    assign dirRight  = heldRight & ~heldLeft;
    assign inRun     = (state == READY) || (state == SETTLE);
    assign limit     = repeating ? CNT_WIDTH'(REPEAT_CYCLES) : CNT_WIDTH'(HOLD_CYCLES);
    assign clrCnt    = !inRun || !(dirLeft || dirRight) || pressLeft || pressRight;
    assign hit       = !clrCnt && (count >= limit - CNT_WIDTH'(1));
    assign rep       = pend | hit;
    assign moveLeft  = dirLeft & ~pressRight & (pressLeft | rep);
    assign moveRight = dirRight & ~pressLeft & (pressRight | rep);
    assign okLeft    = (pt != '0) && !pt[DATAWIDTH-1] && (((pt << 1) & bg) == '0);
    assign okRight   = (pt != '0) && !pt[0] && (((pt >> 1) & bg) == '0);
    always_comb begin
        stateNext   = state;
        shiftNext   = 2'b00;
        blockedNext = 1'b0;
        case (state)
            IDLE:   stateNext = pressStart ? CLEAR : IDLE;
            CLEAR:  stateNext = LOAD;
            LOAD:   stateNext = SETTLE;
            SETTLE: stateNext = READY;
            READY: begin
                if (pressStart) stateNext = CLEAR;
                else if (moveLeft || moveRight) begin
                    if (moveLeft ? okLeft : okRight) begin
                        shiftNext = moveLeft ? 2'b01 : 2'b10;
                        stateNext = SETTLE;
                    end else blockedNext = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end
    // a repeat due while settling is held in pend until the next READY cycle
    always_ff @(posedge SC_RegPOINTTYPE_CLOCK_50 or posedge SC_RegPOINTTYPE_RESET_InHigh) begin
        if (SC_RegPOINTTYPE_RESET_InHigh) begin
            count     <= '0;
            repeating <= 1'b0;
            pend      <= 1'b0;
        end else begin
            count     <= (clrCnt || hit) ? '0 : (count == '1 ? count : count + CNT_WIDTH'(1));
            repeating <= clrCnt ? 1'b0 : (hit | repeating);
            pend      <= !clrCnt && (state != READY) && rep;
        end
    end
    always_ff @(posedge SC_RegPOINTTYPE_CLOCK_50 or posedge SC_RegPOINTTYPE_RESET_InHigh) begin
        if (SC_RegPOINTTYPE_RESET_InHigh) begin
            state                           <= IDLE;
            SC_PointCtrl_clear_OutLow       <= 1'b1;
            SC_PointCtrl_load0_OutLow       <= 1'b1;
            SC_PointCtrl_shiftselection_Out <= 2'b00;
            SC_PointCtrl_data0_OutBUS       <= '0;
            SC_PointCtrl_blocked_Out        <= 1'b0;
            SC_PointCtrl_busy_Out           <= 1'b0;
        end else begin
            state                           <= stateNext;
            SC_PointCtrl_clear_OutLow       <= stateNext != CLEAR;
            SC_PointCtrl_load0_OutLow       <= stateNext != LOAD;
            SC_PointCtrl_shiftselection_Out <= shiftNext;
            SC_PointCtrl_data0_OutBUS       <= (stateNext == CLEAR) ? SC_PointCtrl_piece_InBUS : SC_PointCtrl_data0_OutBUS;
            SC_PointCtrl_blocked_Out        <= blockedNext;
            SC_PointCtrl_busy_Out           <= (stateNext == CLEAR) || (stateNext == LOAD) || (stateNext == SETTLE);
        end
    end
endmodule
